// File: rtl/pb_io_pkg.sv
// Shared constants for the PicoBlaze input-port hub: port_id width,
// default address map of the RTC/keyboard datapath and event flag indices.
package pb_io_pkg;

    localparam int unsigned PB_PORT_ID_W = 8;

    // Default address map seen by the PicoBlaze firmware
    localparam logic [PB_PORT_ID_W-1:0] ADDR_RTC_SEG = 8'h00;
    localparam logic [PB_PORT_ID_W-1:0] ADDR_RTC_MIN = 8'h01;
    localparam logic [PB_PORT_ID_W-1:0] ADDR_RTC_HOR = 8'h02;
    localparam logic [PB_PORT_ID_W-1:0] ADDR_RTC_DIA = 8'h03;
    localparam logic [PB_PORT_ID_W-1:0] ADDR_RTC_MES = 8'h04;
    localparam logic [PB_PORT_ID_W-1:0] ADDR_RTC_ANO = 8'h05;
    localparam logic [PB_PORT_ID_W-1:0] ADDR_STATUS  = 8'h0F;

    // Bit positions of the event flags inside the status word
    localparam int unsigned FLAG_LISTO         = 0;
    localparam int unsigned FLAG_LISTO_LEE     = 1;
    localparam int unsigned FLAG_LISTO_ESCRIBE = 2;

    // Source selected for the in_port register
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_DATA   = 2'd1,
        SEL_STATUS = 2'd2
    } pb_sel_e;

endpackage

// File: rtl/pb_input_port_hub_if.sv
// PicoBlaze input-side bus: port_id/read_strobe from the CPU, data words and
// event sources from the datapath, in_port/event_pending back to the CPU.
interface pb_input_port_hub_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_PORTS = 6,
    parameter int unsigned NUM_FLAGS = 3
);
    import pb_io_pkg::*;

    logic [PB_PORT_ID_W-1:0]     port_id;
    logic                        read_strobe;
    logic [NUM_PORTS*DATA_W-1:0] port_data;
    logic [NUM_FLAGS-1:0]        event_in;
    logic [DATA_W-1:0]           in_port;
    logic                        event_pending;

    // Environment side: CPU strobes plus datapath words and events
    modport master (
        output port_id,
        output read_strobe,
        output port_data,
        output event_in,
        input  in_port,
        input  event_pending
    );

    // Hub side
    modport slave (
        input  port_id,
        input  read_strobe,
        input  port_data,
        input  event_in,
        output in_port,
        output event_pending
    );

endinterface

// File: rtl/pb_event_flag.sv
// One sticky event flag: optional 2-flop synchroniser, rising-edge detect,
// set on edge, clear on request, set wins over a simultaneous clear.
// Build option: INPUT_SYNC_EN adds the synchroniser in front of the edge detector.
module pb_event_flag (
    input  logic clk,
    input  logic rst,
    input  logic event_in,
    input  logic clear,
    output logic flag,
    output logic flag_next_c
);

    logic event_s;
    logic event_q;
    logic edge_c;

`ifdef INPUT_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchroniser for an asynchronous event source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], event_in};
        end
    end

    assign event_s = sync_q[1];
`else
    assign event_s = event_in;
`endif

    // Edge-detect history; a level already high at reset release counts as an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_q <= 1'b0;
        end else begin
            event_q <= event_s;
        end
    end

    // Next flag value: new edge sets, clear drops only an existing flag
    always_comb begin
        edge_c      = event_s & ~event_q;
        flag_next_c = edge_c | (flag & ~clear);
    end

    // Sticky flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag <= 1'b0;
        end else begin
            flag <= flag_next_c;
        end
    end

endmodule

// File: rtl/pb_input_port_hub.sv
// PicoBlaze input-port hub: registered port_id mux over NUM_PORTS data words
// and a status word of sticky event flags that clear on read.
// Build option: INPUT_SYNC_EN synchronises event_in before edge detection.
module pb_input_port_hub
    import pb_io_pkg::*;
#(
    parameter int unsigned              DATA_W      = 8,
    parameter int unsigned              NUM_PORTS   = 6,
    parameter logic [PB_PORT_ID_W-1:0]  BASE_ADDR   = ADDR_RTC_SEG,
    parameter int unsigned              NUM_FLAGS   = 3,
    parameter logic [PB_PORT_ID_W-1:0]  STATUS_ADDR = ADDR_STATUS
) (
    input  logic                 clk,
    input  logic                 rst,
    pb_input_port_hub_if.slave   bus
);

    localparam int unsigned ADDR_LO = 32'(BASE_ADDR);
    localparam int unsigned ADDR_HI = 32'(BASE_ADDR) + NUM_PORTS - 1;

    logic [NUM_FLAGS-1:0] flags;
    logic [NUM_FLAGS-1:0] flags_next;
    logic [NUM_FLAGS-1:0] clear_c;
    logic [DATA_W-1:0]    in_port_q;
    logic [DATA_W-1:0]    word_c;
    logic                 event_pending_q;
    logic                 status_read_c;
    pb_sel_e              sel_c;

    // Address decode: full 8-bit compare, no wrap past 8'hFF
    always_comb begin
        sel_c = SEL_NONE;
        if (bus.port_id == STATUS_ADDR) begin
            sel_c = SEL_STATUS;
        end else if ((32'(bus.port_id) >= ADDR_LO) && (32'(bus.port_id) <= ADDR_HI)) begin
            sel_c = SEL_DATA;
        end
    end

    // Word selected for in_port on the next clock
    always_comb begin
        word_c = '0;
        case (sel_c)
            SEL_DATA: begin
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    if (32'(bus.port_id) == ADDR_LO + k) begin
                        word_c = bus.port_data[k*DATA_W +: DATA_W];
                    end
                end
            end
            SEL_STATUS: begin
                word_c[NUM_FLAGS-1:0] = flags;
            end
            default: begin
                word_c = '0;
            end
        endcase
    end

    // Clear only the flags the CPU is sampling right now on in_port
    always_comb begin
        status_read_c = bus.read_strobe && (bus.port_id == STATUS_ADDR);
        clear_c       = status_read_c ? in_port_q[NUM_FLAGS-1:0] : '0;
    end

    // One sticky flag per event source
    for (genvar i = 0; i < int'(NUM_FLAGS); i++) begin : g_flag
        pb_event_flag u_flag (
            .clk         (clk),
            .rst         (rst),
            .event_in    (bus.event_in[i]),
            .clear       (clear_c[i]),
            .flag        (flags[i]),
            .flag_next_c (flags_next[i])
        );
    end

    // Registered in_port and interrupt-style pending indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_port_q       <= '0;
            event_pending_q <= 1'b0;
        end else begin
            in_port_q       <= word_c;
            event_pending_q <= |flags_next;
        end
    end

    assign bus.in_port       = in_port_q;
    assign bus.event_pending = event_pending_q;

endmodule
